// File: rtl/w5300_bus_ctrl_pkg.sv
// W5300 bus constants shared by the controller and its users.
package W5300;

    // Access direction carried in bit 10 of the request address
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Default bus timing, in clk cycles
    localparam int unsigned SETUP_CYC_DEF   = 1;
    localparam int unsigned STROBE_CYC_DEF  = 4;
    localparam int unsigned RECOVER_CYC_DEF = 2;

endpackage

// File: rtl/w5300_bus_ctrl.sv
// W5300 parallel bus controller: chip reset / PLL lock init, then
// back-to-back unhandshaked accesses timed by one shared down-counter.
module w5300_bus_ctrl
    import W5300::*;
#(
    parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC  = STROBE_CYC_DEF,
    parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int unsigned RST_CYC     = 100,
    parameter int unsigned LOCK_CYC    = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_state,
    output logic        ready,
    output logic        w5300_rst_n,
    output logic        w5300_cs_n,
    output logic        w5300_rd_n,
    output logic        w5300_wr_n,
    output logic [9:0]  w5300_addr,
    output logic [15:0] w5300_data_o,
    input  logic [15:0] w5300_data_i,
    output logic        w5300_data_oe
);

    typedef enum logic [2:0] {
        ChipReset,
        WaitLock,
        Latch,
        Setup,
        Strobe,
        Recover
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        cnt_done;
    logic        lat_wr;

    assign cnt_done = (cnt == '0);

    // Single FSM: every output is registered, the counter is reloaded on state entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ChipReset;
            cnt           <= 32'(RST_CYC - 1);
            ready         <= 1'b0;
            op_state      <= 1'b0;
            rd_data       <= '0;
            lat_wr        <= 1'b0;
            w5300_rst_n   <= 1'b0;
            w5300_cs_n    <= 1'b1;
            w5300_rd_n    <= 1'b1;
            w5300_wr_n    <= 1'b1;
            w5300_data_oe <= 1'b0;
            w5300_addr    <= '0;
            w5300_data_o  <= '0;
        end else begin
            op_state <= 1'b0;
            if (!cnt_done)
                cnt <= cnt - 32'd1;

            unique case (state)
                ChipReset: begin
                    if (cnt_done) begin
                        state       <= WaitLock;
                        cnt         <= 32'(LOCK_CYC - 1);
                        w5300_rst_n <= 1'b1;
                    end
                end
                WaitLock: begin
                    if (cnt_done) begin
                        state <= Latch;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end
                end
                Latch: begin
                    // The output registers double as the latched request
                    state         <= Setup;
                    cnt           <= 32'(SETUP_CYC - 1);
                    lat_wr        <= (addr[10] == WR);
                    w5300_cs_n    <= 1'b0;
                    w5300_addr    <= addr[9:0];
                    w5300_data_o  <= wr_data;
                    w5300_data_oe <= (addr[10] == WR);
                end
                Setup: begin
                    if (cnt_done) begin
                        state      <= Strobe;
                        cnt        <= 32'(STROBE_CYC - 1);
                        w5300_rd_n <= lat_wr;
                        w5300_wr_n <= !lat_wr;
                    end
                end
                Strobe: begin
                    if (cnt_done) begin
                        state      <= Recover;
                        cnt        <= 32'(RECOVER_CYC - 1);
                        w5300_rd_n <= 1'b1;
                        w5300_wr_n <= 1'b1;
                        w5300_cs_n <= 1'b1;
                        if (!lat_wr)
                            rd_data <= w5300_data_i;
                        // Pulse lands on the last Recover cycle, which is the first when RECOVER_CYC==1
                        op_state <= (RECOVER_CYC == 1);
                    end
                end
                Recover: begin
                    if (cnt_done) begin
                        state         <= Latch;
                        cnt           <= '0;
                        w5300_data_oe <= 1'b0;
                    end else begin
                        op_state <= (cnt == 32'd1);
                    end
                end
                default: begin
                    state <= ChipReset;
                    cnt   <= 32'(RST_CYC - 1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// Scoreboard bench for w5300_bus_ctrl: the driver pushes expected accesses,
// a negedge monitor observes the bus and pops on every op_state pulse.
module tb_w5300_bus_ctrl;
    import W5300::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        op_state, ready;
    logic        w5300_rst_n, w5300_cs_n, w5300_rd_n, w5300_wr_n;
    logic [9:0]  w5300_addr;
    logic [15:0] w5300_data_o, w5300_data_i;
    logic        w5300_data_oe;

    w5300_bus_ctrl #(
        .RST_CYC  (10),
        .LOCK_CYC (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .op_state      (op_state),
        .ready         (ready),
        .w5300_rst_n   (w5300_rst_n),
        .w5300_cs_n    (w5300_cs_n),
        .w5300_rd_n    (w5300_rd_n),
        .w5300_wr_n    (w5300_wr_n),
        .w5300_addr    (w5300_addr),
        .w5300_data_o  (w5300_data_o),
        .w5300_data_i  (w5300_data_i),
        .w5300_data_oe (w5300_data_oe)
    );

    always #5 clk = ~clk;

    // Chip model: fixed read contents, garbage outside the read strobe
    function automatic logic [15:0] rom(input logic [9:0] a);
        if (a == 10'h3FE) return 16'h5300;
        return {6'b0, a} ^ 16'hA500;
    endfunction
    assign w5300_data_i = w5300_rd_n ? 16'hDEAD : rom(w5300_addr);

    typedef struct packed {
        logic        wr;
        logic [9:0]  a;
        logic [15:0] wd;
        logic [15:0] rd;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;
    int   err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic wr, input logic [9:0] a, input logic [15:0] wd,
                         input logic [15:0] rdx);
        exp_t e;
        addr    = {(wr ? WR : RD), a};
        wr_data = wd;
        e.wr = wr; e.a = a; e.wd = wd; e.rd = rdx;
        sb.push_back(e);
    endtask

    task automatic wait_op();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (op_state) seen = 1'b1;
        end
        if (!seen) chk("op_timeout", 32'd0, 32'd1);
    endtask

    // Called on the negedge after the reset edge with rst released
    task automatic init_measure();
        int n;
        n = 0;
        while (w5300_rst_n == 1'b0 && n < 1000) begin n++; @(negedge clk); end
        chk("rst_n_low_cycles", n, 10);
        n = 0;
        while (ready == 1'b0 && n < 1000) begin n++; @(negedge clk); end
        chk("lock_wait_cycles", n, 20);
        chk("latch_cs_high", w5300_cs_n, 1'b1);
        @(negedge clk);
        chk("first_cs_fall", w5300_cs_n, 1'b0);
    endtask

    // Monitor: bus invariants every cycle, per-access observations scored on op_state
    int          cyc = 0;
    int          last_op = -1;
    int          cs_hi = 0;
    bit          have_prev = 1'b0;
    logic        prev_cs = 1'b1;
    logic [9:0]  obs_addr = '0;
    int          rd_lo = 0, wr_lo = 0, oe_cnt = 0;
    logic [15:0] d_seen = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        chk("no_dual_strobe", !(!w5300_rd_n && !w5300_wr_n), 1'b1);
        chk("strobe_needs_cs", (w5300_rd_n && w5300_wr_n) || !w5300_cs_n, 1'b1);
        if (!ready)
            chk("init_idle", {op_state, w5300_cs_n, w5300_rd_n, w5300_wr_n}, 4'b0111);
        if (!w5300_rst_n) begin
            have_prev = 1'b0;
            last_op   = -1;
        end
        if (prev_cs && !w5300_cs_n) begin
            if (have_prev) chk("cs_gap", cs_hi, 3);
            have_prev = 1'b1;
            cs_hi     = 0;
            obs_addr  = w5300_addr;
            rd_lo = 0; wr_lo = 0; oe_cnt = 0; d_seen = '0;
        end
        if (w5300_cs_n) cs_hi++;
        if (!w5300_rd_n) rd_lo++;
        if (!w5300_wr_n) begin wr_lo++; d_seen = w5300_data_o; end
        if (w5300_data_oe) oe_cnt++;
        if (op_state) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("acc_addr",  obs_addr, e.a);
                chk("rd_low",    rd_lo,  e.wr ? 0 : 4);
                chk("wr_low",    wr_lo,  e.wr ? 4 : 0);
                chk("oe_cycles", oe_cnt, e.wr ? 7 : 0);
                chk("rd_data",   rd_data, e.rd);
                if (e.wr) chk("wr_data_out", d_seen, e.wd);
            end
            if (last_op >= 0) chk("period", cyc - last_op, 8);
            last_op = cyc;
        end
        prev_cs = w5300_cs_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        issue(1'b0, 10'h3FE, 16'h0000, 16'h5300);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready",    ready, 1'b0);
        chk("rst_op",       op_state, 1'b0);
        chk("rst_rd_data",  rd_data, 16'h0000);
        chk("rst_chip_rst", w5300_rst_n, 1'b0);
        chk("rst_strobes",  {w5300_cs_n, w5300_rd_n, w5300_wr_n}, 3'b111);
        chk("rst_oe",       w5300_data_oe, 1'b0);
        chk("rst_addr",     w5300_addr, 10'h000);
        chk("rst_data_o",   w5300_data_o, 16'h0000);
        rst = 1'b0;
        init_measure();
        wait_op();

        // Write: rd_data keeps the previous read value
        issue(1'b1, 10'h202, 16'h0040, 16'h5300);
        wait_op();

        // Held read request: ten back-to-back accesses
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 10'h001, 16'h0000, 16'hA501);
            wait_op();
        end

        // Address changed during Strobe only affects the following access
        issue(1'b0, 10'h123, 16'h0000, 16'hA423);
        repeat (3) @(negedge clk);
        chk("in_strobe_rd", w5300_rd_n, 1'b0);
        issue(1'b0, 10'h055, 16'h0000, 16'hA555);
        wait_op();
        wait_op();

        // Reset during a write strobe aborts it and restarts init
        issue(1'b1, 10'h0AA, 16'hBEEF, 16'hA555);
        repeat (3) @(negedge clk);
        chk("in_strobe_wr", w5300_wr_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_n",  w5300_wr_n, 1'b1);
        chk("abort_oe",    w5300_data_oe, 1'b0);
        chk("abort_rst_n", w5300_rst_n, 1'b0);
        chk("abort_ready", ready, 1'b0);
        chk("abort_cs_n",  w5300_cs_n, 1'b1);
        chk("abort_rd",    rd_data, 16'h0000);
        sb.delete();
        issue(1'b0, 10'h3FE, 16'h0000, 16'h5300);
        rst = 1'b0;
        init_measure();
        wait_op();
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
